// File: rtl/mvm_seq_pkg.sv
// +----------------------------------------------------------------------+
// | mvm_seq_pkg : shared opcode and state encodings for mvm_seq_ctrl     |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package mvm_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_M         = 2'd0,
    OP_LOAD_V         = 2'd1,
    OP_COMPUTE        = 2'd2,
    OP_LOAD_V_COMPUTE = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_M_PULSE  = 4'd1,
    S_M_STREAM = 4'd2,
    S_V_PULSE  = 4'd3,
    S_V_STREAM = 4'd4,
    S_C_WAITQ  = 4'd5,
    S_C_START  = 4'd6,
    S_C_WAIT   = 4'd7,
    S_C_LAT    = 4'd8,
    S_C_CAPT   = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mvm_result_fifo.sv
// +----------------------------------------------------------------------+
// | mvm_result_fifo : synchronous FIFO buffering engine results          |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module mvm_result_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  // Empty reads as zero so the output port is quiet after reset.
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mvm_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | mvm_seq_ctrl : command sequencer driving a stall-free MVM engine      |
// | Option       : MVM_SEQ_CTRL_PERF_EN adds the perf_cycles output      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module mvm_seq_ctrl
  import mvm_seq_pkg::*;
#(
  parameter int K       = 32,
  parameter int B       = 8,
  parameter int OUT_LAT = 1,
  parameter int TIMEOUT = 2048
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           mvm_load_matrix,
  output logic           mvm_load_vector,
  output logic           mvm_start,
  output logic [B-1:0]   mvm_data_in,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data_out,
  output logic           busy,
  output logic           matrix_loaded,
  output logic           proto_err,
  output logic           cmd_err,
  output logic           timeout_err
`ifdef MVM_SEQ_CTRL_PERF_EN
  , output logic [31:0]  perf_cycles
`endif
);

  localparam int c_cnt_w  = $clog2(K * K + 1);
  localparam int c_wdog_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]  c_mat_last  = c_cnt_w'(K * K - 1);
  localparam logic [c_cnt_w-1:0]  c_vec_last  = c_cnt_w'(K - 1);
  localparam logic [c_cnt_w-1:0]  c_lat_last  = c_cnt_w'((OUT_LAT > 1) ? OUT_LAT - 2 : 0);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);

  state_t              r_state, w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_wdog_w-1:0] r_wdog;
  logic r_matrix_loaded, r_vector_loaded, r_then_compute;
  logic r_proto_err, r_cmd_err, r_timeout_err;
  logic w_accept, w_stream, w_push, w_fifo_full, w_fifo_empty;
  logic w_set_m, w_set_v, w_set_cmd_err, w_set_timeout;

  assign cmd_ready       = (r_state == S_IDLE) & ~reset;
  assign w_accept        = cmd_valid & cmd_ready;
  assign w_stream        = (r_state == S_M_STREAM) || (r_state == S_V_STREAM);
  assign in_ready        = w_stream;
  assign mvm_data_in     = w_stream ? in_data : '0;
  assign mvm_load_matrix = (r_state == S_M_PULSE);
  assign mvm_load_vector = (r_state == S_V_PULSE);
  assign mvm_start       = (r_state == S_C_START);
  assign busy            = (r_state != S_IDLE);
  assign matrix_loaded   = r_matrix_loaded;
  assign proto_err       = r_proto_err;
  assign cmd_err         = r_cmd_err;
  assign timeout_err     = r_timeout_err;
  assign out_valid       = ~w_fifo_empty;

  always_comb begin
    w_next        = r_state;
    w_set_m       = 1'b0;
    w_set_v       = 1'b0;
    w_set_cmd_err = 1'b0;
    w_set_timeout = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_t'(cmd_op))
            OP_LOAD_M:  w_next = S_M_PULSE;
            OP_COMPUTE: begin
              if (r_matrix_loaded && r_vector_loaded) w_next = S_C_WAITQ;
              else                                    w_set_cmd_err = 1'b1;
            end
            default:    w_next = S_V_PULSE;
          endcase
        end
      end
      S_M_PULSE:  w_next = S_M_STREAM;
      S_M_STREAM: begin
        if (r_cnt == c_mat_last) begin
          w_next  = S_IDLE;
          w_set_m = 1'b1;
        end
      end
      S_V_PULSE:  w_next = S_V_STREAM;
      S_V_STREAM: begin
        if (r_cnt == c_vec_last) begin
          w_set_v = 1'b1;
          // The vector just completed, so only the matrix flag gates the chained compute.
          if (r_then_compute && r_matrix_loaded) w_next = S_C_WAITQ;
          else begin
            w_next        = S_IDLE;
            w_set_cmd_err = r_then_compute;
          end
        end
      end
      S_C_WAITQ:  if (w_fifo_empty) w_next = S_C_START;
      S_C_START:  w_next = S_C_WAIT;
      S_C_WAIT: begin
        if (mvm_done) w_next = (OUT_LAT > 1) ? S_C_LAT : S_C_CAPT;
        else if (r_wdog == c_wdog_last) begin
          w_next        = S_IDLE;
          w_set_timeout = 1'b1;
        end
      end
      S_C_LAT:    if (r_cnt == c_lat_last) w_next = S_C_CAPT;
      S_C_CAPT: begin
        w_push = 1'b1;
        if (r_cnt == c_vec_last) w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // r_cnt counts cycles spent in the current state; it restarts on every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_wdog          <= '0;
      r_matrix_loaded <= 1'b0;
      r_vector_loaded <= 1'b0;
      r_then_compute  <= 1'b0;
      r_proto_err     <= 1'b0;
      r_cmd_err       <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + c_cnt_w'(1);
      r_wdog  <= (r_state == S_C_WAIT) ? r_wdog + c_wdog_w'(1) : '0;
      if (w_accept)      r_then_compute  <= (op_t'(cmd_op) == OP_LOAD_V_COMPUTE);
      if (w_set_m)       r_matrix_loaded <= 1'b1;
      if (w_set_v)       r_vector_loaded <= 1'b1;
      if (w_set_cmd_err) r_cmd_err       <= 1'b1;
      if (w_set_timeout) r_timeout_err   <= 1'b1;
      if (w_stream && !in_valid) r_proto_err <= 1'b1;
    end
  end

  mvm_result_fifo #(
    .DEPTH (K),
    .W     (2 * B)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push & ~w_fifo_full),
    .push_data (mvm_data_out),
    .pop       (out_valid & out_ready),
    .pop_data  (out_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

`ifdef MVM_SEQ_CTRL_PERF_EN
  logic [31:0] r_perf_run;
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_run    <= '0;
      r_perf_cycles <= '0;
    end else begin
      r_perf_run <= (r_state == S_C_START) ? 32'd1 : r_perf_run + 32'd1;
      if (r_state == S_C_CAPT && r_cnt == c_vec_last) r_perf_cycles <= r_perf_run;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule

`default_nettype wire
